// File: rtl/aes_rk_sched.sv
// aes_rk_sched: round-key sequencer and store for the AES core.
// Drives the key-expansion stage (init/set/round/mode) through a full schedule,
// captures each registered round key into a local store, then serves indexed
// reads with one-cycle latency.
// Build option: define AES_RK_REVERSE_EN to read in decryption order
// (rd_idx 0 returns round key Nr); left undefined, reads use rd_idx directly.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; ke_mode and store contents hold
// ST_GEN   | c = 0..Nr, one round index per cycle driven to key expansion
// ST_FLUSH | one cycle for the last round key to land in the store
// ST_DONE  | done pulse, keys_valid set, back to idle
module aes_rk_sched #(
  parameter int unsigned NR_MAX = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic         ke_init,
  output logic         ke_set,
  output logic [4:0]   ke_round,
  output logic [1:0]   ke_mode,
  input  logic [127:0] ke_roundkey,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic         rd_valid,
  output logic [127:0] rd_key
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] NR_MAX_4 = 4'(NR_MAX);

  // Last round index for a key-size select; unknown codes fall back to AES-128.
  function automatic logic [3:0] nr_of(input logic [1:0] m);
    case (m)
      2'd2:    return 4'd12;
      2'd3:    return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  state_t        state_q;
  logic [3:0]    c_q;
  logic          busy_q;
  logic          done_q;
  logic          keys_valid_q;
  logic          ke_init_q;
  logic          ke_set_q;
  logic [4:0]    ke_round_q;
  logic [1:0]    ke_mode_q;

  logic          cap_q;
  logic [3:0]    cap_idx_q;
  logic [127:0]  store_q [0:NR_MAX];

  logic          rd_valid_q;
  logic [127:0]  rd_key_q;
  logic [127:0]  rd_key_d;
  logic [3:0]    rd_eff;
  logic          rd_hit;
  logic [3:0]    nr;

  // Nr always follows the latched mode, so it stays stable for a whole schedule.
  assign nr = nr_of(ke_mode_q);

  // Sequencer: one state register plus registered strobes to key expansion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      c_q          <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      ke_init_q    <= 1'b0;
      ke_set_q     <= 1'b0;
      ke_round_q   <= 5'd0;
      ke_mode_q    <= 2'd0;
    end else begin
      done_q    <= 1'b0;
      ke_init_q <= 1'b0;
      ke_set_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= ST_GEN;
            ke_mode_q    <= mode;
            keys_valid_q <= 1'b0;
            c_q          <= 4'd0;
            ke_round_q   <= 5'd0;
            ke_init_q    <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_GEN: begin
          if (c_q == nr) begin
            state_q <= ST_FLUSH;
          end else begin
            c_q        <= c_q + 4'd1;
            ke_round_q <= {1'b0, c_q + 4'd1};
            // Second key half is loaded on GEN cycle 1 for 192/256-bit keys.
            ke_set_q   <= (c_q == 4'd0) && ke_mode_q[1];
          end
        end
        ST_FLUSH: begin
          state_q      <= ST_DONE;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          keys_valid_q <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Capture strobe trails GEN by one cycle to match the key-expansion register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q     <= 1'b0;
      cap_idx_q <= 4'd0;
    end else begin
      cap_q     <= (state_q == ST_GEN);
      cap_idx_q <= c_q;
    end
  end

  // Round-key store; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (cap_q && (cap_idx_q <= NR_MAX_4)) begin
      store_q[cap_idx_q] <= ke_roundkey;
    end
  end

`ifdef AES_RK_REVERSE_EN
  assign rd_eff = nr - rd_idx;
`else
  assign rd_eff = rd_idx;
`endif

  assign rd_hit = keys_valid_q && (rd_idx <= nr) && (rd_eff <= NR_MAX_4);

  // Read mux: out-of-range indices and incomplete schedules return zero.
  always_comb begin
    rd_key_d = '0;
    if (rd_hit) begin
      rd_key_d = store_q[rd_eff];
    end
  end

  // Read pipeline register: one-cycle latency, a new read every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_key_q <= rd_key_d;
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = keys_valid_q;
  assign ke_init    = ke_init_q;
  assign ke_set     = ke_set_q;
  assign ke_round   = ke_round_q;
  assign ke_mode    = ke_mode_q;
  assign rd_valid   = rd_valid_q;
  assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_aes_rk_sched.sv
// Bench for aes_rk_sched with a behavioural AES key expansion attached.
// Honours AES_RK_REVERSE_EN so the same vectors apply to either read order.
module tb_aes_rk_sched;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic         ke_init;
  logic         ke_set;
  logic [4:0]   ke_round;
  logic [1:0]   ke_mode;
  logic [127:0] ke_roundkey;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic         rd_valid;
  logic [127:0] rd_key;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] rk_tab [0:14];

  aes_rk_sched #(.NR_MAX(14)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .busy        (busy),
    .done        (done),
    .keys_valid  (keys_valid),
    .ke_init     (ke_init),
    .ke_set      (ke_set),
    .ke_round    (ke_round),
    .ke_mode     (ke_mode),
    .ke_roundkey (ke_roundkey),
    .rd_en       (rd_en),
    .rd_idx      (rd_idx),
    .rd_valid    (rd_valid),
    .rd_key      (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key-expansion stand-in: registers the round key for the index it is driven.
  always @(posedge clk) ke_roundkey <= rk_tab[ke_round[3:0]];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int i = 1; i < 256; i++) if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic int nr_of(input logic [1:0] m);
    return (m == 2'd2) ? 12 : (m == 2'd3) ? 14 : 10;
  endfunction

  // FIPS-197 key expansion into round keys 0..nr; key is MSB-aligned.
  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= 14; r++)
      rk_tab[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : {4{32'hbad0bad0}};
  endtask

  // rd_idx that selects logical round r under the build's read order.
  function automatic logic [3:0] ridx(input int r, input int nr);
`ifdef AES_RK_REVERSE_EN
    return 4'(nr - r);
`else
    return 4'(r);
`endif
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic rd(input logic [3:0] idx, output logic v, output logic [127:0] k);
    @(negedge clk);
    rd_en = 1'b1; rd_idx = idx;
    @(negedge clk);
    v = rd_valid; k = rd_key;
    rd_en = 1'b0;
  endtask

  // Runs one schedule (or two back-to-back with start held) and checks every
  // cycle after accept. Cycle j is sampled on the negedge after j-1 edges past accept.
  task automatic run_sched(input logic [1:0] m, input bit held, input string tag);
    int nr, span, jj;
    logic [6:0] exp_st, act_st;
    nr = nr_of(m);
    span = held ? 2*nr + 7 : nr + 4;
    @(negedge clk);
    start = 1'b1; mode = m; rd_en = 1'b1; rd_idx = 4'd0;
    for (int j = 1; j <= span; j++) begin
      @(negedge clk);
      jj = (held && j > nr + 4) ? j - (nr + 4) : j;
      exp_st = {(jj >= 1 && jj <= nr + 2), (jj == nr + 3), (jj >= nr + 3),
                (jj == 1), (jj == 2 && m[1]), m};
      act_st = {busy, done, keys_valid, ke_init, ke_set, ke_mode};
      chk($sformatf("%s_status_c%0d", tag, j), 128'(act_st), 128'(exp_st));
      if (jj >= 1 && jj <= nr + 1)
        chk($sformatf("%s_round_c%0d", tag, j), 128'(ke_round), 128'(jj - 1));
      if (j >= 2 && j <= nr + 3)
        chk($sformatf("%s_busy_read_c%0d", tag, j), {rd_valid, rd_key[126:0]},
            {1'b1, 127'h0});
      if (!held) begin
        start = 1'b0;
        mode = 2'(m + 2'd1);
      end
    end
    start = 1'b0; rd_en = 1'b0;
  endtask

  task automatic read_all(input logic [1:0] m, input string tag);
    int nr;
    logic v;
    logic [127:0] k, e;
    nr = nr_of(m);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), v, k);
`ifdef AES_RK_REVERSE_EN
      e = (i <= nr) ? rk_tab[nr - i] : 128'h0;
`else
      e = (i <= nr) ? rk_tab[i] : 128'h0;
`endif
      chk($sformatf("%s_idx%0d", tag, i), {127'h0, v} ^ (k << 1), {127'h0, 1'b1} ^ (e << 1));
      chk($sformatf("%s_idx%0d_msb", tag, i), 128'(k[127]), 128'(e[127]));
    end
  endtask

  typedef struct {
    string        name;
    logic [1:0]   m;
    int           rnd;
    logic [127:0] exp;
  } rvec_t;

  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    rvec_t tv [0:7];
    logic v;
    logic [127:0] k;

    tv[0] = '{"k128_r0",  2'd1, 0,  128'h000102030405060708090a0b0c0d0e0f};
    tv[1] = '{"k128_r1",  2'd1, 1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    tv[2] = '{"k128_r10", 2'd1, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    tv[3] = '{"k128_r11", 2'd1, 11, 128'h0};
    tv[4] = '{"k256_r0",  2'd3, 0,  128'h000102030405060708090a0b0c0d0e0f};
    tv[5] = '{"k256_r1",  2'd3, 1,  128'h101112131415161718191a1b1c1d1e1f};
    tv[6] = '{"k256_r14", 2'd3, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    tv[7] = '{"k256_r15", 2'd3, 15, 128'h0};

    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    for (int r = 0; r <= 14; r++) rk_tab[r] = '0;

    rst_n = 1'b0; start = 1'b0; mode = 2'd0; rd_en = 1'b0; rd_idx = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 128'({busy, done, keys_valid, ke_init, ke_set, ke_round, ke_mode}), 128'h0);
    chk("reset_rd", {rd_key[127:1], rd_valid}, 128'h0);
    rst_n = 1'b1;

    // AES-128
    expand(KEY128, 4, 10);
    run_sched(2'd1, 1'b0, "aes128");
    for (int i = 0; i < 8; i++) begin
      if (tv[i].m == 2'd1) begin
        rd(ridx(tv[i].rnd, 10), v, k);
        chk(tv[i].name, k, tv[i].exp);
        chk({tv[i].name, "_valid"}, 128'(v), 128'h1);
      end
    end
    @(negedge clk);
    chk("rd_valid_drop", 128'(rd_valid), 128'h0);
    read_all(2'd1, "aes128_all");

    // AES-256
    expand(KEY256, 8, 14);
    run_sched(2'd3, 1'b0, "aes256");
    for (int i = 0; i < 8; i++) begin
      if (tv[i].m == 2'd3) begin
        rd(ridx(tv[i].rnd, 14), v, k);
        chk(tv[i].name, k, tv[i].exp);
      end
    end
    read_all(2'd3, "aes256_all");

    // AES-192
    expand(KEY192, 6, 12);
    run_sched(2'd2, 1'b0, "aes192");
    read_all(2'd2, "aes192_all");

    // start held high: back-to-back AES-128 schedules via the fallback mode code
    expand(KEY128, 4, 10);
    run_sched(2'd0, 1'b1, "held");
    repeat (2) @(negedge clk);
    chk("held_idle", 128'({busy, ke_init}), 128'h0);
    rd(ridx(10, 10), v, k);
    chk("held_r10", k, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Reset in the middle of an AES-256 schedule (GEN cycle 5)
    expand(KEY256, 8, 14);
    @(negedge clk);
    start = 1'b1; mode = 2'd3; rd_en = 1'b1; rd_idx = 4'd0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midrst_pre_round", 128'({busy, ke_round, ke_mode, rd_valid}), 128'({1'b1, 5'd5, 2'd3, 1'b1}));
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 128'({busy, done, keys_valid, ke_init, ke_set, ke_round, ke_mode}), 128'h0);
    chk("midrst_rd", {rd_key[127:1], rd_valid}, 128'h0);
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_stays_idle", 128'({busy, done, keys_valid}), 128'h0);
    rd(4'd0, v, k);
    chk("midrst_read_valid", 128'(v), 128'h1);
    chk("midrst_read_zero", k, 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
